raster_engine: RTL and testbench
================================

Name: raster_engine

Overview:
- Sits directly downstream of the command decoder in the 8x8 rasterizer.
- Consumes the decoded command (2 bits), coordinates x1 and y1, and the one-cycle command_valid pulse.
- Executes draw operations into an 8x8 one-bit framebuffer.
- Exposes a registered row-read port for the display/output stage, plus busy/done/overflow status.

Parameters:
- CLEAR_PATTERN, 8'h00, row value written to every row by CMD_CLEAR (8'hFF gives a fill-screen variant).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- command  in  2  decoded opcode: 00 PLOT, 01 ERASE, 10 HLINE, 11 CLEAR
- x1  in  3  column coordinate, 0..7
- y1  in  3  row coordinate, 0..7
- command_valid  in  1  one-cycle strobe; command/x1/y1 are valid in this cycle
- rd_row  in  3  row index to read
- rd_data  out  8  registered row contents; bit x = pixel (x, rd_row)
- busy  out  1  multi-cycle operation in progress
- done  out  1  one-cycle pulse when an operation completes
- overflow  out  1  sticky: a command arrived while busy and was dropped
- ovf_clr  in  1  synchronous clear of overflow

Behaviour:
- Clock and reset. Single clock clk. Reset is asynchronous on rst_n low (active-low) and is fixed.
- Reset values. Framebuffer all 0, rd_data=0, busy=0, done=0, overflow=0, state=IDLE, cur_x=0, cur_row=0.
- Reset mid-operation. Aborts immediately. Framebuffer is zeroed, not set to CLEAR_PATTERN.
- States: IDLE, HLINE, CLEAR.
- Acceptance. A command is accepted at rising edge E only when state==IDLE and command_valid==1.
- PLOT and ERASE:
  - fb[y1][x1] is set (PLOT) or cleared (ERASE) at edge E.
  - done=1 for the single cycle following E.
  - busy stays 0; back-to-back PLOTs every cycle are all accepted.
- HLINE:
  - At E: cur_x<=x1, cur_row<=y1, state<=HLINE, busy<=1.
  - Each edge in HLINE sets fb[cur_row][cur_x].
  - If cur_x==7: state<=IDLE, busy<=0, done<=1 for one cycle. Otherwise cur_x<=cur_x+1.
  - Occupancy is 8-x1 cycles in HLINE; x1=7 takes 1 cycle. No wrap past column 7.
- CLEAR:
  - At E: cur_row<=0, state<=CLEAR, busy<=1.
  - Each edge writes fb[cur_row]<=CLEAR_PATTERN.
  - At cur_row==7: state<=IDLE, busy<=0, done pulse. Always exactly 8 cycles.
- busy is registered and equals (state!=IDLE).
- Dropped commands. command_valid in any cycle with state!=IDLE is dropped, including the final working cycle, and sets overflow<=1. The framebuffer is unaffected.
- Overflow clear. ovf_clr=1 clears overflow. If a drop and ovf_clr occur in the same cycle, the set wins.
- Read port:
  - rd_data<=fb[rd_row] every edge; latency 1 cycle.
  - A read and write to the same row at the same edge returns the pre-write value. The new value is visible one cycle later.
- Done pulse. done is never high for more than 1 consecutive cycle unless completions occur in consecutive cycles (e.g. back-to-back PLOTs).
- Width rules. All coordinates are 3-bit unsigned. The cur_x increment is checked against 7 before incrementing, so no 3-bit overflow occurs.

Decomposition:
- Shared package raster_pkg:
  - CMD_PLOT=2'b00, CMD_ERASE=2'b01, CMD_HLINE=2'b10, CMD_CLEAR=2'b11.
  - GRID_DIM=8, COORD_W=3.
  - Engine state encoding (IDLE/HLINE/CLEAR). The command decoder imports the same CMD_* constants.
- One sub-module: raster_fb.
  - 8x8 register array with a single write port: row index, 8-bit bit-mask, 8-bit data. Masked bits take the data value.
  - Registered read port (rd_row -> rd_data).
  - Asynchronous active-low reset to zero.
  - The engine FSM drives the write port. PLOT/ERASE/HLINE use a one-hot mask; CLEAR uses mask 8'hFF.

Test Plan:
- Reset, then read rows 0..7 -> rd_data=8'h00 each, one cycle after rd_row is applied. Assert rst_n low during an HLINE -> busy=0 and framebuffer zeroed asynchronously.
- PLOT (3,5), then ERASE (3,5) on the next cycle -> rd_row=5 gives 8'h08, then 8'h00. done pulses on both; busy never rises.
- HLINE x1=2, y1=4 -> busy high for exactly 6 cycles, single done pulse. rd_row=4 gives 8'hFC; all other rows stay 8'h00.
- HLINE x1=7, y1=0 -> busy for 1 cycle, row0=8'h80. Issue a PLOT (0,0) during that busy cycle -> dropped, row0 still 8'h80, overflow=1. Pulse ovf_clr -> overflow=0.
- Fill rows with PLOTs, then CLEAR (CLEAR_PATTERN=8'h00) -> busy for exactly 8 cycles, all rows 8'h00. Repeat with CLEAR_PATTERN=8'hFF -> all rows 8'hFF.
- Read/write collision: PLOT (1,2) while rd_row=2 at the same edge -> rd_data shows the old value that cycle and 8'h02 the next.

Source files
------------

// File: rtl/raster_pkg.sv
// raster_pkg: shared opcodes, grid geometry and engine state encoding for the 8x8 rasterizer
package raster_pkg;
    localparam int GRID_DIM = 8;
    localparam int COORD_W  = 3;
    localparam logic [1:0] CMD_PLOT  = 2'b00;
    localparam logic [1:0] CMD_ERASE = 2'b01;
    localparam logic [1:0] CMD_HLINE = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;
    typedef enum logic [1:0] {IDLE, HLINE, CLEAR} state_t;
    function automatic logic [GRID_DIM-1:0] col_mask(input logic [COORD_W-1:0] x);
        return {{(GRID_DIM-1){1'b0}}, 1'b1} << x;
    endfunction
endpackage

// File: rtl/raster_fb.sv
// raster_fb: 8x8 one-bit framebuffer with one masked row write port and a registered row read
module raster_fb
    import raster_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [COORD_W-1:0]  wr_row,
    input  logic [GRID_DIM-1:0] wr_mask,
    input  logic [GRID_DIM-1:0] wr_data,
    input  logic [COORD_W-1:0]  rd_row,
    output logic [GRID_DIM-1:0] rd_data
);
    logic [GRID_DIM-1:0] fb [GRID_DIM];

    // the read samples the pre-write row, so a same-edge write shows up one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb      <= '{default: '0};
            rd_data <= '0;
        end else begin
            rd_data <= fb[rd_row];
            if (we) fb[wr_row] <= (fb[wr_row] & ~wr_mask) | (wr_data & wr_mask);
        end
    end
endmodule

// File: rtl/raster_engine.sv
// raster_engine: executes PLOT/ERASE/HLINE/CLEAR commands into the framebuffer
module raster_engine
    import raster_pkg::*;
#(
    parameter logic [GRID_DIM-1:0] CLEAR_PATTERN = 8'h00
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          command,
    input  logic [COORD_W-1:0]  x1,
    input  logic [COORD_W-1:0]  y1,
    input  logic                command_valid,
    input  logic [COORD_W-1:0]  rd_row,
    output logic [GRID_DIM-1:0] rd_data,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    input  logic                ovf_clr
);
    state_t state, state_n;
    logic [COORD_W-1:0] cur_x, cur_x_n, cur_row, cur_row_n;
    logic done_n, we;
    logic [COORD_W-1:0] wr_row;
    logic [GRID_DIM-1:0] wr_mask, wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_x    <= '0;
            cur_row  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            cur_x    <= cur_x_n;
            cur_row  <= cur_row_n;
            busy     <= state_n != IDLE;
            done     <= done_n;
            overflow <= (command_valid && state != IDLE) ? 1'b1 : ovf_clr ? 1'b0 : overflow;
        end
    end

    always_comb begin
        state_n   = state;
        cur_x_n   = cur_x;
        cur_row_n = cur_row;
        done_n    = 1'b0;
        we        = 1'b0;
        wr_row    = y1;
        wr_mask   = col_mask(x1);
        wr_data   = '0;
        case (state)
            IDLE: if (command_valid) begin
                case (command)
                    CMD_PLOT: begin
                        we      = 1'b1;
                        wr_data = '1;
                        done_n  = 1'b1;
                    end
                    CMD_ERASE: begin
                        we     = 1'b1;
                        done_n = 1'b1;
                    end
                    CMD_HLINE: begin
                        state_n   = HLINE;
                        cur_x_n   = x1;
                        cur_row_n = y1;
                    end
                    default: begin
                        state_n   = CLEAR;
                        cur_row_n = '0;
                    end
                endcase
            end
            HLINE: begin
                we      = 1'b1;
                wr_row  = cur_row;
                wr_mask = col_mask(cur_x);
                wr_data = '1;
                if (cur_x == 3'd7) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else cur_x_n = cur_x + 3'd1;
            end
            CLEAR: begin
                we      = 1'b1;
                wr_row  = cur_row;
                wr_mask = '1;
                wr_data = CLEAR_PATTERN;
                if (cur_row == 3'd7) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else cur_row_n = cur_row + 3'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    raster_fb u_fb (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .wr_row  (wr_row),
        .wr_mask (wr_mask),
        .wr_data (wr_data),
        .rd_row  (rd_row),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_raster_engine.sv
// tb_raster_engine: directed and random checks of two engines (clear to 00 and to FF) against a pixel model
module tb_raster_engine;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [1:0] command = '0;
    logic [2:0] x1 = '0, y1 = '0, rd_row = '0;
    logic command_valid = 1'b0, ovf_clr = 1'b0;
    logic [7:0] rd0, rd1;
    logic busy0, busy1, done0, done1, ovf0, ovf1;
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    raster_engine #(.CLEAR_PATTERN(8'h00)) dut0 (
        .clk(clk), .rst_n(rst_n), .command(command), .x1(x1), .y1(y1),
        .command_valid(command_valid), .rd_row(rd_row), .rd_data(rd0),
        .busy(busy0), .done(done0), .overflow(ovf0), .ovf_clr(ovf_clr));
    raster_engine #(.CLEAR_PATTERN(8'hFF)) dut1 (
        .clk(clk), .rst_n(rst_n), .command(command), .x1(x1), .y1(y1),
        .command_valid(command_valid), .rd_row(rd_row), .rd_data(rd1),
        .busy(busy1), .done(done1), .overflow(ovf1), .ovf_clr(ovf_clr));

    // model: pending multi-cycle work is a queue of row writes, one retired per busy cycle
    typedef struct {logic [2:0] row; logic [7:0] mask; logic clr;} wr_t;
    wr_t q[$];
    wr_t w;
    logic [7:0] m_fb [2][8];
    logic [7:0] m_rd [2];
    logic m_done, m_ovf;

    function automatic logic [7:0] pat(int p);
        return p == 0 ? 8'h00 : 8'hFF;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                m_rd[p] = 8'h00;
                for (int r = 0; r < 8; r++) m_fb[p][r] = 8'h00;
            end
            m_done = 1'b0;
            m_ovf = 1'b0;
            q.delete();
        end else begin
            for (int p = 0; p < 2; p++) m_rd[p] = m_fb[p][rd_row];
            m_done = 1'b0;
            if (q.size() != 0) begin
                if (command_valid) m_ovf = 1'b1;
                else if (ovf_clr) m_ovf = 1'b0;
                w = q.pop_front();
                for (int p = 0; p < 2; p++)
                    m_fb[p][w.row] = w.clr ? pat(p) : (m_fb[p][w.row] | w.mask);
                m_done = q.size() == 0;
            end else begin
                if (ovf_clr) m_ovf = 1'b0;
                if (command_valid) begin
                    case (command)
                        2'b00: begin
                            for (int p = 0; p < 2; p++) m_fb[p][y1][x1] = 1'b1;
                            m_done = 1'b1;
                        end
                        2'b01: begin
                            for (int p = 0; p < 2; p++) m_fb[p][y1][x1] = 1'b0;
                            m_done = 1'b1;
                        end
                        2'b10: for (int c = int'(x1); c < 8; c++) q.push_back('{y1, 8'(1 << c), 1'b0});
                        default: for (int r = 0; r < 8; r++) q.push_back('{3'(r), 8'h00, 1'b1});
                    endcase
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("rd_data0", rd0, m_rd[0]);
        chk("rd_data1", rd1, m_rd[1]);
        chk("busy0", {7'd0, busy0}, {7'd0, q.size() != 0});
        chk("busy1", {7'd0, busy1}, {7'd0, q.size() != 0});
        chk("done0", {7'd0, done0}, {7'd0, m_done});
        chk("done1", {7'd0, done1}, {7'd0, m_done});
        chk("ovf0", {7'd0, ovf0}, {7'd0, m_ovf});
        chk("ovf1", {7'd0, ovf1}, {7'd0, m_ovf});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic cmd(input logic [1:0] c, input logic [2:0] x, input logic [2:0] y);
        command = c;
        x1 = x;
        y1 = y;
        command_valid = 1'b1;
        step();
        command_valid = 1'b0;
    endtask

    task automatic count_busy(output int n, output int d);
        n = 0;
        d = 0;
        for (int i = 0; i < 20 && busy0; i++) begin
            n++;
            d += int'(done0);
            step();
        end
        d += int'(done0);
    endtask

    task automatic read_row(input logic [2:0] r);
        rd_row = r;
        step();
    endtask

    int nb, nd;

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int r = 0; r < 8; r++) begin
            read_row(3'(r));
            chk("reset_row", rd0, 8'h00);
        end
        rd_row = 3'd5;
        cmd(2'b00, 3'd3, 3'd5);
        chk("plot_done", {7'd0, done0}, 8'h01);
        cmd(2'b01, 3'd3, 3'd5);
        chk("plot_row", rd0, 8'h08);
        chk("erase_done", {7'd0, done0}, 8'h01);
        step();
        chk("erase_row", rd0, 8'h00);
        cmd(2'b10, 3'd2, 3'd4);
        count_busy(nb, nd);
        chk("hline_busy", 8'(nb), 8'd6);
        chk("hline_done", 8'(nd), 8'd1);
        for (int r = 0; r < 8; r++) begin
            read_row(3'(r));
            chk("hline_row", rd0, r == 4 ? 8'hFC : 8'h00);
        end
        cmd(2'b10, 3'd7, 3'd0);
        chk("hl7_busy", {7'd0, busy0}, 8'h01);
        cmd(2'b00, 3'd0, 3'd0);
        chk("drop_ovf", {7'd0, ovf0}, 8'h01);
        chk("hl7_idle", {7'd0, busy0}, 8'h00);
        read_row(3'd0);
        chk("hl7_row", rd0, 8'h80);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", {7'd0, ovf0}, 8'h00);
        for (int c = 0; c < 8; c++) cmd(2'b00, 3'(c), 3'(c));
        cmd(2'b11, 3'd0, 3'd0);
        count_busy(nb, nd);
        chk("clear_busy", 8'(nb), 8'd8);
        chk("clear_done", 8'(nd), 8'd1);
        for (int r = 0; r < 8; r++) begin
            read_row(3'(r));
            chk("clear00_row", rd0, 8'h00);
            chk("clearFF_row", rd1, 8'hFF);
        end
        rd_row = 3'd2;
        cmd(2'b00, 3'd1, 3'd2);
        chk("coll_old", rd0, 8'h00);
        step();
        chk("coll_new", rd0, 8'h02);
        for (int i = 0; i < 600; i++) begin
            command = 2'($urandom_range(0, 3));
            x1 = 3'($urandom_range(0, 7));
            y1 = 3'($urandom_range(0, 7));
            rd_row = 3'($urandom_range(0, 7));
            command_valid = $urandom_range(0, 2) == 0;
            ovf_clr = $urandom_range(0, 7) == 0;
            step();
        end
        command_valid = 1'b0;
        ovf_clr = 1'b0;
        repeat (10) step();
        cmd(2'b10, 3'd0, 3'd3);
        repeat (2) step();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", {7'd0, busy0}, 8'h00);
        chk("rst_rd", rd0, 8'h00);
        step();
        rst_n = 1'b1;
        for (int r = 0; r < 8; r++) begin
            read_row(3'(r));
            chk("rst_row", rd0, 8'h00);
            chk("rst_row1", rd1, 8'h00);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
